// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the program-counter / instruction-fetch stage.
// The PC_INC / PC_JUMP codes match what the control decoder drives.
package pc_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  // SYSCALL encoding; the decoder treats it as a NOP
  localparam logic [31:0] NOP_INS_DEFAULT  = 32'h0000_000C;

  // Decoder PC_INC field
  typedef enum logic [1:0] {
    PC_INC_NORMAL = 2'b00,
    PC_INC_BRANCH = 2'b01,
    PC_INC_JUMP   = 2'b10,
    PC_INC_STOP   = 2'b11
  } pc_inc_e;

  // Decoder PC_JUMP field, meaningful only together with PC_INC_JUMP
  typedef enum logic {
    PC_JUMP_REG  = 1'b0,
    PC_JUMP_IMME = 1'b1
  } pc_jump_e;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    FS_RST   = 2'b00,
    FS_FETCH = 2'b01,
    FS_EXEC  = 2'b10,
    FS_HALT  = 2'b11
  } fetch_state_e;

  // True for the PC_INC codes that move on to the next instruction;
  // anything else (STOP or an unknown code) halts the core.
  function automatic logic pc_inc_advances(input logic [1:0] code);
    return (code == PC_INC_NORMAL) || (code == PC_INC_BRANCH) ||
           (code == PC_INC_JUMP);
  endfunction

  // Branch displacement: sign-extended word offset converted to bytes
  function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// Instruction-memory request/response bus.
// The fetch stage is the master; the instruction memory is the slave.
interface pc_fetch_if;
  import pc_fetch_pkg::*;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );

endinterface

// File: rtl/pc_next.sv
// Purely combinational next-PC selection for the fetch stage.
// Chooses between sequential, branch, absolute-jump and register-jump targets.
module pc_next
  import pc_fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] ir_low,        // IR[25:0]: jump index, low half is imm16
  input  logic [1:0]  pc_inc,
  input  logic        pc_jump,
  input  logic        branch_taken,
  input  logic [31:0] jr_target,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  logic [31:0] branch_pc;
  logic [31:0] jump_imm_pc;
  logic [31:0] jump_reg_pc;

  // 32-bit modulo arithmetic: 0xFFFF_FFFC + 4 wraps to 0
  assign pc_plus4    = pc + 32'd4;
  assign branch_pc   = pc_plus4 + branch_offset(ir_low[15:0]);
  assign jump_imm_pc = {pc_plus4[31:28], ir_low, 2'b00};
  // Register targets are forced word-aligned by dropping the low two bits
  assign jump_reg_pc = jr_target & 32'hFFFF_FFFC;

  // Select the target for the current PC_INC / PC_JUMP combination
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    next_pc = pc;
    case (pc_inc)
      PC_INC_NORMAL: next_pc = pc_plus4;
      PC_INC_BRANCH: next_pc = branch_taken ? branch_pc : pc_plus4;
      PC_INC_JUMP:   next_pc = (pc_jump == PC_JUMP_IMME) ? jump_imm_pc : jump_reg_pc;
      default:       next_pc = pc;   // STOP / unknown: PC stays put
    endcase
  end

endmodule

// File: rtl/pc_fetch.sv
// Program counter and instruction-fetch stage feeding the control decoder.
// Each instruction takes a FETCH phase (imem handshake) followed by an EXEC
// phase during which the instruction register drives the decoder.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INS  = NOP_INS_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         pc_inc,
  input  logic               pc_jump,
  input  logic               branch_taken,
  input  logic [31:0]        jr_target,
  input  logic               mem_stall,
  pc_fetch_if.master         imem,
  output logic [31:0]        ins,
  output logic               ins_valid,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic               halted
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  ir_q;
  logic         req_q;
  logic         ins_valid_q;
  logic         halted_q;
  logic [31:0]  next_pc;

  pc_next u_pc_next (
    .pc           (pc_q),
    .ir_low       (ir_q[25:0]),
    .pc_inc       (pc_inc),
    .pc_jump      (pc_jump),
    .branch_taken (branch_taken),
    .jr_target    (jr_target),
    .pc_plus4     (pc_plus4),
    .next_pc      (next_pc)
  );

  // Fetch sequencer: state, PC, IR and the registered status outputs move together
  // NOTE: the reset is asynchronous, so a reset mid-FETCH drops any outstanding request at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q     <= FS_RST;
      pc_q        <= RESET_PC;
      ir_q        <= 32'h0;
      req_q       <= 1'b0;
      ins_valid_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      case (state_q)
        FS_RST: begin
          state_q <= FS_FETCH;
          req_q   <= 1'b1;
        end

        FS_FETCH: begin
          // Address is pc_q, which cannot change while waiting here
          if (imem.imem_ready) begin
            ir_q        <= imem.imem_rdata;
            state_q     <= FS_EXEC;
            req_q       <= 1'b0;
            ins_valid_q <= 1'b1;
          end
        end

        FS_EXEC: begin
          // A datapath stall freezes the instruction and the PC
          if (!mem_stall) begin
            ins_valid_q <= 1'b0;
            if (pc_inc_advances(pc_inc)) begin
              pc_q    <= next_pc;
              state_q <= FS_FETCH;
              req_q   <= 1'b1;
            end else begin
              state_q  <= FS_HALT;
              halted_q <= 1'b1;
            end
          end
        end

        default: begin
          // FS_HALT is terminal until the next reset
          state_q     <= FS_HALT;
          req_q       <= 1'b0;
          ins_valid_q <= 1'b0;
          halted_q    <= 1'b1;
        end
      endcase
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign ins            = ins_valid_q ? ir_q : NOP_INS;
  assign ins_valid      = ins_valid_q;
  assign pc             = pc_q;
  assign halted         = halted_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed testbench for pc_fetch: walks the PC through sequential, branch,
// jump and wrap-around cases with hand-computed expected values.
module tb_pc_fetch;
  import pc_fetch_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [1:0]  pc_inc;
  logic        pc_jump;
  logic        branch_taken;
  logic [31:0] jr_target;
  logic        mem_stall;
  logic [31:0] ins;
  logic        ins_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        halted;

  int checks = 0;
  int errors = 0;

  pc_fetch_if imem_bus ();

  pc_fetch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_inc       (pc_inc),
    .pc_jump      (pc_jump),
    .branch_taken (branch_taken),
    .jr_target    (jr_target),
    .mem_stall    (mem_stall),
    .imem         (imem_bus.master),
    .ins          (ins),
    .ins_valid    (ins_valid),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Serve one fetch: hold ready low for wait_cycles, then return word
  task automatic fetch(input logic [31:0] word, input int wait_cycles, input logic [31:0] exp_addr);
    for (int i = 0; i < wait_cycles; i++) begin
      check("wait_req", 32'(imem_bus.imem_req), 32'd1);
      check("wait_addr", imem_bus.imem_addr, exp_addr);
      check("wait_ins", ins, 32'h0000_000C);
      check("wait_valid", 32'(ins_valid), 32'd0);
      imem_bus.imem_ready = 1'b0;
      tick();
    end
    check("fetch_req", 32'(imem_bus.imem_req), 32'd1);
    check("fetch_addr", imem_bus.imem_addr, exp_addr);
    imem_bus.imem_ready = 1'b1;
    imem_bus.imem_rdata = word;
    tick();
    imem_bus.imem_ready = 1'b0;
    imem_bus.imem_rdata = 32'h0;
    check("exec_ins", ins, word);
    check("exec_valid", 32'(ins_valid), 32'd1);
    check("exec_req", 32'(imem_bus.imem_req), 32'd0);
  endtask

  // Run the EXEC phase, optionally stalled; imem_ready is pulsed to show it is ignored
  task automatic exec(input logic [1:0] inc, input logic jmp, input logic taken,
                      input logic [31:0] jr, input int stall_cycles, input logic [31:0] exp_pc);
    logic [31:0] pc_before;
    logic [31:0] ins_before;
    pc_before    = pc;
    ins_before   = ins;
    pc_inc       = inc;
    pc_jump      = jmp;
    branch_taken = taken;
    jr_target    = jr;
    for (int i = 0; i < stall_cycles; i++) begin
      mem_stall           = 1'b1;
      imem_bus.imem_ready = 1'b1;
      imem_bus.imem_rdata = 32'hDEAD_BEEF;
      tick();
      check("stall_pc", pc, pc_before);
      check("stall_ins", ins, ins_before);
      check("stall_valid", 32'(ins_valid), 32'd1);
    end
    mem_stall           = 1'b0;
    imem_bus.imem_ready = 1'b0;
    imem_bus.imem_rdata = 32'h0;
    tick();
    check("next_pc", pc, exp_pc);
    pc_inc       = PC_INC_NORMAL;
    pc_jump      = PC_JUMP_REG;
    branch_taken = 1'b0;
    jr_target    = 32'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n               = 1'b0;
    pc_inc              = PC_INC_NORMAL;
    pc_jump             = PC_JUMP_REG;
    branch_taken        = 1'b0;
    jr_target           = 32'h0;
    mem_stall           = 1'b0;
    imem_bus.imem_ready = 1'b0;
    imem_bus.imem_rdata = 32'h0;
    tick();
    tick();

    // 1. reset state, one idle cycle, first fetch and sequential advance
    check("rst_pc", pc, 32'h0000_3000);
    check("rst_req", 32'(imem_bus.imem_req), 32'd0);
    check("rst_valid", 32'(ins_valid), 32'd0);
    check("rst_ins", ins, 32'h0000_000C);
    check("rst_halted", 32'(halted), 32'd0);
    rst_n = 1'b1;
    check("rst_idle_req", 32'(imem_bus.imem_req), 32'd0);
    tick();
    fetch(32'h2008_0005, 0, 32'h0000_3000);
    check("plus4", pc_plus4, 32'h0000_3004);
    exec(PC_INC_NORMAL, PC_JUMP_REG, 1'b0, 32'h0, 0, 32'h0000_3004);
    check("back_to_fetch", 32'(imem_bus.imem_req), 32'd1);

    // 2. backward branch taken, then not taken, both from 0x3010
    fetch(32'h0000_0008, 0, 32'h0000_3004);
    exec(PC_INC_JUMP, PC_JUMP_REG, 1'b0, 32'h0000_3010, 0, 32'h0000_3010);
    fetch(32'h1000_FFFC, 0, 32'h0000_3010);
    exec(PC_INC_BRANCH, PC_JUMP_REG, 1'b1, 32'h0, 0, 32'h0000_3004);
    fetch(32'h0000_0008, 0, 32'h0000_3004);
    exec(PC_INC_JUMP, PC_JUMP_REG, 1'b0, 32'h0000_3010, 0, 32'h0000_3010);
    fetch(32'h1000_FFFC, 0, 32'h0000_3010);
    exec(PC_INC_BRANCH, PC_JUMP_REG, 1'b0, 32'h0, 0, 32'h0000_3014);

    // 3. absolute jump inside the 256 MB region, then register jump with low bits dropped
    fetch(32'h0000_0008, 0, 32'h0000_3014);
    exec(PC_INC_JUMP, PC_JUMP_REG, 1'b0, 32'h0040_0008, 0, 32'h0040_0008);
    fetch(32'h0810_0000, 0, 32'h0040_0008);
    exec(PC_INC_JUMP, PC_JUMP_IMME, 1'b0, 32'h0, 0, 32'h0040_0000);
    fetch(32'h0000_0008, 0, 32'h0040_0000);
    exec(PC_INC_JUMP, PC_JUMP_REG, 1'b0, 32'h0000_1237, 0, 32'h0000_1234);

    // 4. slow memory, then 5. stalled EXEC and PC wrap-around
    fetch(32'h0000_0008, 3, 32'h0000_1234);
    exec(PC_INC_JUMP, PC_JUMP_REG, 1'b0, 32'hFFFF_FFFC, 2, 32'hFFFF_FFFC);
    check("wrap_plus4", pc_plus4, 32'h0000_0000);
    fetch(32'h0000_0000, 1, 32'hFFFF_FFFC);
    exec(PC_INC_NORMAL, PC_JUMP_REG, 1'b0, 32'h0, 0, 32'h0000_0000);

    // 6. halt is sticky and ignores imem_ready
    fetch(32'h0000_000D, 0, 32'h0000_0000);
    exec(PC_INC_STOP, PC_JUMP_REG, 1'b0, 32'h0, 0, 32'h0000_0000);
    imem_bus.imem_ready = 1'b1;
    imem_bus.imem_rdata = 32'h1234_5678;
    tick();
    tick();
    imem_bus.imem_ready = 1'b0;
    check("halt_flag", 32'(halted), 32'd1);
    check("halt_pc", pc, 32'h0000_0000);
    check("halt_req", 32'(imem_bus.imem_req), 32'd0);
    check("halt_ins", ins, 32'h0000_000C);
    check("halt_valid", 32'(ins_valid), 32'd0);

    // Reset out of HALT, advance once, then assert reset mid-FETCH
    rst_n = 1'b0;
    #1;
    check("rst_from_halt", 32'(halted), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    fetch(32'h0000_0000, 0, 32'h0000_3000);
    exec(PC_INC_NORMAL, PC_JUMP_REG, 1'b0, 32'h0, 0, 32'h0000_3004);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_pc", pc, 32'h0000_3000);
    check("async_rst_req", 32'(imem_bus.imem_req), 32'd0);
    tick();
    rst_n = 1'b1;
    check("post_rst_idle", 32'(imem_bus.imem_req), 32'd0);
    tick();
    fetch(32'h2008_0005, 0, 32'h0000_3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
